vga_rect_engine: RTL and testbench
==================================

// Module: vga_rect_engine
// PURPOSE
// Parametrised pixel-write engine that drives the x/y/colour/plot inputs of vga_adapter.
// Accepts one command at a time: filled rectangle, rectangle outline, or full-screen clear.
// Emits at most one pixel per clock, clipped to the configured screen size.
// Sits between game/control logic and the single vga_adapter instance in each top level.
// PARAMETERS
// SCREEN_W   160  horizontal resolution in pixels (matches vga_adapter RESOLUTION)
// SCREEN_H   120  vertical resolution in pixels
// X_W        8    x coordinate / width bits; must satisfy 2**X_W >= SCREEN_W
// Y_W        7    y coordinate / height bits; must satisfy 2**Y_W >= SCREEN_H
// COLOUR_W   3    colour bits, 3*BITS_PER_COLOUR_CHANNEL of vga_adapter
// PORTS
// CLOCK_50   in   1         system clock, all logic on rising edge
// resetn     in   1         synchronous, active-low reset
// start      in   1         command request; accepted only when ready=1
// mode       in   2         2'b00 FILL, 2'b01 OUTLINE, 2'b10 CLEAR, 2'b11 reserved (treated as FILL)
// x0         in   X_W       rectangle left column
// y0         in   Y_W       rectangle top row
// w          in   X_W       rectangle width in pixels; 0 = empty
// h          in   Y_W       rectangle height in pixels; 0 = empty
// colour_in  in   COLOUR_W  draw colour; CLEAR uses it as the background colour
// ready      out  1         engine idle, start will be accepted this cycle
// done       out  1         one-cycle pulse when a command completes
// x          out  X_W       pixel column to vga_adapter
// y          out  Y_W       pixel row to vga_adapter
// colour     out  COLOUR_W  pixel colour to vga_adapter
// plot       out  1         write-enable to vga_adapter
// BEHAVIOUR
// - Reset (resetn=0 at an edge): state IDLE, ready=1, done=0, plot=0, x=0, y=0, colour=0.
//   Reset mid-command aborts it; no done pulse is produced for the aborted command.
// - All outputs are registered. FSM states: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
// - IDLE: ready=1. On edge k with start=1, latch mode/x0/y0/w/h/colour_in and go to LOAD; ready=0.
//   start while ready=0 is ignored (not queued).
// - LOAD (edge k+1): compute clipped bounds in X_W+1 / Y_W+1 bit arithmetic (no wrap):
//   xe = min(x0+w-1, SCREEN_W-1), ye = min(y0+h-1, SCREEN_H-1).
//   CLEAR: x0=y0=0, xe=SCREEN_W-1, ye=SCREEN_H-1.
//   Empty if w=0, h=0, x0>=SCREEN_W or y0>=SCREEN_H -> go straight to DONE.
// - DRAW: edges k+2 .. k+1+N present one pixel per cycle, raster order, x inner, y outer;
//   N = (xe-x0+1)*(ye-y0+1). colour = latched colour on every DRAW cycle.
//   FILL/CLEAR: plot=1 on every DRAW cycle.
//   OUTLINE: plot=1 only if x==x0, y==y0, x==x0+w-1 or y==y0+h-1 (unclipped edges);
//   interior cycles still consumed with plot=0. Clipped-away edges are not drawn.
// - DONE: done=1 and ready=1 for exactly one cycle, plot=0; return to IDLE.
//   A start asserted in the DONE cycle is accepted (ready=1).
// - Outside DRAW: plot=0; x/y/colour hold their last value.
// - Single pixel (w=h=1): N=1, plot on edge k+2, done on edge k+3.
// STRUCTURE
// - Shared include vga_defs.vh: mode encodings (MODE_FILL/OUTLINE/CLEAR), default
//   SCREEN_W/H, X_W/Y_W, COLOUR_W; reused by future sprite/text engines.
// - One sub-module: vga_clip (combinational clip of x0/y0/w/h to xe/ye plus empty flag),
//   registered by the LOAD state. FSM, x/y counters and outline test live in this module.
// TESTING
// - resetn=0 for 2 cycles during a CLEAR -> plot=0, ready=1, done=0 next cycle; no done later.
// - FILL x0=10,y0=20,w=3,h=2,colour=3'b100, start at edge k -> plot at k+2..k+7 on
//   (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); done=1 at k+8 only.
// - FILL x0=158,y0=119,w=5,h=4 -> exactly (158,119),(159,119) plotted; done at k+4.
// - OUTLINE x0=0,y0=0,w=4,h=3 -> 12 DRAW cycles, plot=0 only at (1,1),(2,1); done at k+14.
// - CLEAR colour=3'b000 -> 19200 plot cycles, first (0,0), last (159,119); done at k+19202.
// - w=0 -> no plot, done at k+2; start pulsed during DRAW -> ignored, pixel count unchanged.

Source files
------------

// File: rtl/vga_rect_engine_pkg.sv
// Shared definitions for the VGA pixel engines: command encodings, default
// screen geometry, engine FSM states and small command-decode helpers.
package vga_rect_engine_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;

    localparam logic [1:0] MODE_FILL    = 2'b00;
    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;
    localparam logic [1:0] MODE_RSVD    = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_clear(input logic [1:0] mode);
        return (mode == MODE_CLEAR);
    endfunction

    // The reserved encoding falls through to FILL, so only OUTLINE masks pixels.
    function automatic logic is_outline(input logic [1:0] mode);
        return (mode == MODE_OUTLINE);
    endfunction

endpackage

// File: rtl/vga_clip.sv
// Combinational clip of a rectangle request against the screen: start corner,
// clipped end corner and an empty flag. CLEAR covers the whole screen.
module vga_clip
    import vga_rect_engine_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W
) (
    input  logic           i_clear,
    input  logic [X_W-1:0] i_x0,
    input  logic [Y_W-1:0] i_y0,
    input  logic [X_W-1:0] i_w,
    input  logic [Y_W-1:0] i_h,
    output logic [X_W-1:0] o_xs,
    output logic [Y_W-1:0] o_ys,
    output logic [X_W-1:0] o_xe,
    output logic [Y_W-1:0] o_ye,
    output logic           o_empty
);

    localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
    localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);
    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    logic [X_W:0] w_x_end_raw;
    logic [Y_W:0] w_y_end_raw;

    // One extra bit keeps x0+w-1 from wrapping before the clamp.
    always_comb begin
        w_x_end_raw = {1'b0, i_x0} + {1'b0, i_w} - {{X_W{1'b0}}, 1'b1};
        w_y_end_raw = {1'b0, i_y0} + {1'b0, i_h} - {{Y_W{1'b0}}, 1'b1};
        if (i_clear) begin
            o_xs    = {X_W{1'b0}};
            o_ys    = {Y_W{1'b0}};
            o_xe    = X_MAX[X_W-1:0];
            o_ye    = Y_MAX[Y_W-1:0];
            o_empty = 1'b0;
        end else begin
            o_xs = i_x0;
            o_ys = i_y0;
            if (w_x_end_raw > X_MAX) begin
                o_xe = X_MAX[X_W-1:0];
            end else begin
                o_xe = w_x_end_raw[X_W-1:0];
            end
            if (w_y_end_raw > Y_MAX) begin
                o_ye = Y_MAX[Y_W-1:0];
            end else begin
                o_ye = w_y_end_raw[Y_W-1:0];
            end
            o_empty = (i_w == {X_W{1'b0}}) || (i_h == {Y_W{1'b0}}) ||
                      ({1'b0, i_x0} >= X_LIM) || ({1'b0, i_y0} >= Y_LIM);
        end
    end

endmodule

// File: rtl/vga_rect_engine.sv
// Pixel-write engine for vga_adapter: one FILL / OUTLINE / CLEAR command at a
// time, emitting at most one clipped pixel per clock in raster order.
module vga_rect_engine
    import vga_rect_engine_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COLOUR_W = DEF_COLOUR_W
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      w,
    input  logic [Y_W-1:0]      h,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                ready,
    output logic                done,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot
);

    logic [1:0]          r_state;
    logic [1:0]          r_mode;
    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [X_W-1:0]      r_w;
    logic [Y_W-1:0]      r_h;
    logic [COLOUR_W-1:0] r_col;
    logic [X_W-1:0]      r_xs;
    logic [X_W-1:0]      r_xe;
    logic [Y_W-1:0]      r_ye;
    logic [X_W-1:0]      r_cx;
    logic [Y_W-1:0]      r_cy;
    logic                r_ready;
    logic                r_done;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_plot;

    logic [X_W-1:0] w_xs;
    logic [Y_W-1:0] w_ys;
    logic [X_W-1:0] w_xe;
    logic [Y_W-1:0] w_ye;
    logic           w_empty;
    logic [X_W:0]   w_x_last;
    logic [Y_W:0]   w_y_last;
    logic           w_on_edge;
    logic           w_plot_now;
    logic           w_last_px;

    vga_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_clip (
        .i_clear (is_clear(r_mode)),
        .i_x0    (r_x0),
        .i_y0    (r_y0),
        .i_w     (r_w),
        .i_h     (r_h),
        .o_xs    (w_xs),
        .o_ys    (w_ys),
        .o_xe    (w_xe),
        .o_ye    (w_ye),
        .o_empty (w_empty)
    );

    // Outline test uses the unclipped far edges, so clipped-away sides never plot.
    always_comb begin
        w_x_last  = {1'b0, r_x0} + {1'b0, r_w} - {{X_W{1'b0}}, 1'b1};
        w_y_last  = {1'b0, r_y0} + {1'b0, r_h} - {{Y_W{1'b0}}, 1'b1};
        w_on_edge = (r_cx == r_x0) || (r_cy == r_y0) ||
                    ({1'b0, r_cx} == w_x_last) || ({1'b0, r_cy} == w_y_last);
        w_last_px = (r_cx == r_xe) && (r_cy == r_ye);
        if (is_outline(r_mode)) begin
            w_plot_now = w_on_edge;
        end else begin
            w_plot_now = 1'b1;
        end
    end

    // Command FSM, raster counters and registered adapter outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_mode   <= MODE_FILL;
            r_x0     <= {X_W{1'b0}};
            r_y0     <= {Y_W{1'b0}};
            r_w      <= {X_W{1'b0}};
            r_h      <= {Y_W{1'b0}};
            r_col    <= {COLOUR_W{1'b0}};
            r_xs     <= {X_W{1'b0}};
            r_xe     <= {X_W{1'b0}};
            r_ye     <= {Y_W{1'b0}};
            r_cx     <= {X_W{1'b0}};
            r_cy     <= {Y_W{1'b0}};
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_x      <= {X_W{1'b0}};
            r_y      <= {Y_W{1'b0}};
            r_colour <= {COLOUR_W{1'b0}};
            r_plot   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                    if (start) begin
                        r_mode  <= mode;
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_w     <= w;
                        r_h     <= h;
                        r_col   <= colour_in;
                        r_ready <= 1'b0;
                        r_state <= ST_LOAD;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_plot <= 1'b0;
                    r_xs   <= w_xs;
                    r_xe   <= w_xe;
                    r_ye   <= w_ye;
                    r_cx   <= w_xs;
                    r_cy   <= w_ys;
                    if (w_empty) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    r_plot   <= w_plot_now;
                    r_x      <= r_cx;
                    r_y      <= r_cy;
                    r_colour <= r_col;
                    if (r_cx == r_xe) begin
                        r_cx <= r_xs;
                        r_cy <= r_cy + {{(Y_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_cx <= r_cx + {{(X_W-1){1'b0}}, 1'b1};
                    end
                    if (w_last_px) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DRAW;
                    end
                end
                ST_DONE: begin
                    r_plot  <= 1'b0;
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_plot  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign done   = r_done;
    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;

endmodule

// File: tb/tb_vga_rect_engine.sv
// Directed bench for vga_rect_engine: hand-computed pixel sequences and
// done-pulse timing for FILL, clipped FILL, OUTLINE, CLEAR, empty and reset cases.
module tb_vga_rect_engine;
    import vga_rect_engine_pkg::*;

    logic       CLOCK_50;
    logic       resetn;
    logic       start;
    logic [1:0] mode;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [7:0] w;
    logic [6:0] h;
    logic [2:0] colour_in;
    logic       ready;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    int n_vec = 0;
    int n_err = 0;

    vga_rect_engine dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .start     (start),
        .mode      (mode),
        .x0        (x0),
        .y0        (y0),
        .w         (w),
        .h         (h),
        .colour_in (colour_in),
        .ready     (ready),
        .done      (done),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a command so it is sampled at the next edge (edge k); returns just after it.
    task automatic issue(input logic [1:0] m, input int xx, input int yy,
                         input int ww, input int hh, input logic [2:0] c);
        mode      = m;
        x0        = xx[7:0];
        y0        = yy[6:0];
        w         = ww[7:0];
        h         = hh[6:0];
        colour_in = c;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic chk_px(input string tag, input int ex, input int ey, input logic [2:0] ec);
        chk({tag, ".plot"}, 32'(plot), 32'd1);
        chk({tag, ".x"}, 32'(x), ex);
        chk({tag, ".y"}, 32'(y), ey);
        chk({tag, ".colour"}, 32'(colour), 32'(ec));
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".ready"}, 32'(ready), 32'd1);
        chk({tag, ".plot"}, 32'(plot), 32'd0);
    endtask

    initial begin
        int cnt;
        int done_at;
        int first_x;
        int first_y;
        int last_x;
        int last_y;
        logic exp_p;

        resetn = 1'b0; start = 1'b0; mode = MODE_FILL;
        x0 = 8'd0; y0 = 7'd0; w = 8'd0; h = 7'd0; colour_in = 3'b000;
        tick(); tick();
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.plot", 32'(plot), 32'd0);
        chk("rst.x", 32'(x), 32'd0);
        chk("rst.y", 32'(y), 32'd0);
        chk("rst.colour", 32'(colour), 32'd0);
        resetn = 1'b1;
        tick();

        // FILL 3x2 at (10,20): pixels at k+2..k+7, done at k+8 only.
        issue(MODE_FILL, 10, 20, 3, 2, 3'b100);
        chk("fill.k.ready", 32'(ready), 32'd0);
        tick();
        chk("fill.k1.plot", 32'(plot), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_px("fill.px", 10 + i % 3, 20 + i / 3, 3'b100);
        end
        tick();
        chk_done("fill.k8");
        tick();
        chk("fill.k9.done", 32'(done), 32'd0);
        chk("fill.k9.hold_x", 32'(x), 32'd12);
        chk("fill.k9.hold_y", 32'(y), 32'd21);

        // Clipped at bottom-right corner: two pixels, done at k+4.
        issue(MODE_FILL, 158, 119, 5, 4, 3'b010);
        tick();
        tick(); chk_px("clip.px0", 158, 119, 3'b010);
        tick(); chk_px("clip.px1", 159, 119, 3'b010);
        tick(); chk_done("clip.k4");
        tick();

        // OUTLINE 4x3 at origin; a start during DRAW must be ignored.
        issue(MODE_OUTLINE, 0, 0, 4, 3, 3'b001);
        tick();
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) start = 1'b1;
            tick();
            start = 1'b0;
            exp_p = !((i / 4 == 1) && (i % 4 == 1 || i % 4 == 2));
            chk("outline.plot", 32'(plot), 32'(exp_p));
            chk("outline.done", 32'(done), 32'd0);
            if (plot) begin
                cnt++;
                chk("outline.x", 32'(x), i % 4);
                chk("outline.y", 32'(y), i / 4);
            end
        end
        chk("outline.count", cnt, 32'd10);
        tick(); chk_done("outline.k14");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("outline.idle.plot", 32'(plot), 32'd0);
            chk("outline.idle.ready", 32'(ready), 32'd1);
        end

        // Empty commands: done at k+2, no plot.
        issue(MODE_FILL, 5, 5, 0, 3, 3'b111);
        tick(); chk("w0.k1.plot", 32'(plot), 32'd0);
        tick(); chk_done("w0.k2");
        tick();
        issue(MODE_FILL, 160, 5, 4, 3, 3'b111);
        tick(); chk("xoff.k1.plot", 32'(plot), 32'd0);
        tick(); chk_done("xoff.k2");
        tick();

        // Reserved mode draws like FILL.
        issue(MODE_RSVD, 50, 60, 2, 2, 3'b101);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_px("rsvd.px", 50 + i % 2, 60 + i / 2, 3'b101);
        end
        tick(); chk_done("rsvd.k6");
        tick();

        // Single pixel, then a new command accepted in the done cycle.
        issue(MODE_FILL, 7, 9, 1, 1, 3'b011);
        tick();
        tick(); chk_px("one.k2", 7, 9, 3'b011);
        tick(); chk_done("one.k3");
        issue(MODE_FILL, 20, 30, 1, 1, 3'b110);
        chk("b2b.k.ready", 32'(ready), 32'd0);
        tick();
        tick(); chk_px("b2b.k2", 20, 30, 3'b110);
        tick(); chk_done("b2b.k3");
        tick();

        // Full-screen CLEAR with cycle budget.
        issue(MODE_CLEAR, 33, 44, 3, 3, 3'b110);
        cnt = 0; done_at = -1;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        for (int c = 1; c <= 19300; c++) begin
            tick();
            if (plot) begin
                if (cnt == 0) begin
                    first_x = x; first_y = y;
                    chk("clear.first_cycle", c, 32'd2);
                    chk("clear.colour", 32'(colour), 32'd6);
                end
                last_x = x; last_y = y;
                cnt++;
            end
            if (done) begin
                done_at = c;
                break;
            end
        end
        chk("clear.count", cnt, 32'd19200);
        chk("clear.done_at", done_at, 32'd19202);
        chk("clear.first_x", first_x, 32'd0);
        chk("clear.first_y", first_y, 32'd0);
        chk("clear.last_x", last_x, 32'd159);
        chk("clear.last_y", last_y, 32'd119);
        tick();

        // Reset for two cycles in the middle of a CLEAR aborts it silently.
        issue(MODE_CLEAR, 0, 0, 0, 0, 3'b001);
        for (int i = 0; i < 10; i++) tick();
        chk("abort.pre.plot", 32'(plot), 32'd1);
        resetn = 1'b0;
        tick();
        chk("abort.plot", 32'(plot), 32'd0);
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.done", 32'(done), 32'd0);
        tick();
        resetn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || plot) cnt++;
        end
        chk("abort.no_activity", cnt, 32'd0);
        chk("abort.ready_after", 32'(ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
